// File: rtl/norm_pkg.sv
// Shared definitions for the norm pipeline: operand widths, FP zero, feeder states.
package norm_pkg;

    localparam int unsigned DEF_WORD  = 24;
    localparam int unsigned DEF_LEN_W = 16;

    // Encoding used to pad the y operand of an odd-length vector.
    localparam logic [DEF_WORD-1:0] FP_ZERO = 24'h000000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_GET_X,
        ST_GET_Y,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_e;

    // States in which the feeder takes elements from the input stream.
    function automatic logic takes_input(input state_e s);
        return (s == ST_GET_X) || (s == ST_GET_Y);
    endfunction

endpackage

// File: rtl/norm_feeder.sv
// Pairs a stream of vector elements into (x, y) operands for the norm
// accumulator and sequences its clear/enable strobes for one vector per start.
module norm_feeder #(
    parameter int unsigned      WORD    = norm_pkg::DEF_WORD,
    parameter int unsigned      LEN_W   = norm_pkg::DEF_LEN_W,
    parameter logic [WORD-1:0]  FP_ZERO = WORD'(norm_pkg::FP_ZERO)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  vec_len,
    input  logic [WORD-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD-1:0]   x,
    output logic [WORD-1:0]   y,
    output logic              acc_en,
    output logic              acc_clr,
    output logic              busy,
    output logic              done,
    output logic              len_err
);

    norm_pkg::state_e   state_q, state_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [WORD-1:0]    x_q, x_d;
    logic [WORD-1:0]    y_q, y_d;
    logic               in_ready_q, in_ready_d;
    logic               acc_en_q, acc_en_d;
    logic               acc_clr_q, acc_clr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               len_err_q, len_err_d;
    logic               xfer_c;

    // in_ready_q already reflects the current state, so this is the handshake.
    assign xfer_c = in_valid & in_ready_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= norm_pkg::ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, element counting, operand capture and registered strobe decode.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        x_d       = x_q;
        y_d       = y_q;
        len_err_d = 1'b0;

        unique case (state_q)
            norm_pkg::ST_IDLE: begin
                if (start) begin
                    if (vec_len != '0) begin
                        rem_d   = vec_len;
                        state_d = norm_pkg::ST_CLEAR;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            norm_pkg::ST_CLEAR: begin
                state_d = norm_pkg::ST_GET_X;
            end
            norm_pkg::ST_GET_X: begin
                if (xfer_c) begin
                    x_d   = in_data;
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        // Odd tail: pair the last element with zero.
                        y_d     = FP_ZERO;
                        state_d = norm_pkg::ST_ISSUE;
                    end else begin
                        state_d = norm_pkg::ST_GET_Y;
                    end
                end
            end
            norm_pkg::ST_GET_Y: begin
                if (xfer_c) begin
                    y_d     = in_data;
                    rem_d   = rem_q - LEN_W'(1);
                    state_d = norm_pkg::ST_ISSUE;
                end
            end
            norm_pkg::ST_ISSUE: begin
                state_d = (rem_q == '0) ? norm_pkg::ST_WAIT : norm_pkg::ST_GET_X;
            end
            norm_pkg::ST_WAIT: begin
                state_d = norm_pkg::ST_DONE;
            end
            norm_pkg::ST_DONE: begin
                state_d = norm_pkg::ST_IDLE;
            end
            default: begin
                state_d = norm_pkg::ST_IDLE;
            end
        endcase

        // Strobes are decoded from the next state so the registered copies
        // line up with the state they belong to.
        in_ready_d = norm_pkg::takes_input(state_d);
        acc_clr_d  = (state_d == norm_pkg::ST_CLEAR);
        acc_en_d   = (state_d == norm_pkg::ST_ISSUE);
        busy_d     = (state_d != norm_pkg::ST_IDLE);
        done_d     = (state_d == norm_pkg::ST_DONE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            in_ready_q <= 1'b0;
            acc_en_q   <= 1'b0;
            acc_clr_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            rem_q      <= rem_d;
            x_q        <= x_d;
            y_q        <= y_d;
            in_ready_q <= in_ready_d;
            acc_en_q   <= acc_en_d;
            acc_clr_q  <= acc_clr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            len_err_q  <= len_err_d;
        end
    end

    assign in_ready = in_ready_q;
    assign x        = x_q;
    assign y        = y_q;
    assign acc_en   = acc_en_q;
    assign acc_clr  = acc_clr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign len_err  = len_err_q;

endmodule
